cp0_exc_sequencer: RTL and testbench
====================================

// Module: cp0_exc_sequencer
// PURPOSE
//  Sequences exception/interrupt entry and ERET for the CP0 block. Picks one event per committed
//  instruction (interrupt > sync exception > ERET), flushes the pipeline, then drives a 1-cycle
//  exception/ERET record to CP0 together with the PC redirect. Also synchronises external HW interrupts.
// PARAMETERS
//  N_HWINT       6             number of external interrupt lines (Cause.IP[7:2])
//  FLUSH_CYCLES  2             minimum cycles flush_req stays high (>=1)
//  EXC_VECTOR    32'hBFC00380  redirect target for interrupts/exceptions (BEV=1)
// PORTS
//  clk            in   1   clock
//  resetn         in   1   reset; asynchronous, active-low
//  ext_int        in   N_HWINT  async HW interrupt lines, level, active-high
//  timer_int      in   1   timer interrupt level from CP0
//  status_ie/exl/erl in 1 each  CP0 Status bits
//  status_im      in   8   CP0 Status.IM
//  cause_ip_sw    in   2   CP0 Cause.IP[1:0]
//  cp0_epc        in   32  CP0 EPC, read in REDIRECT
//  commit_valid   in   1   instruction at commit this cycle
//  commit_pc      in   32  its PC
//  commit_ds      in   1   it sits in a delay slot
//  commit_exc     in   1   it raised a sync exception
//  commit_code    in   5   ExcCode of that exception
//  commit_badva   in   32  BadVAddr for AdEL/AdES
//  commit_eret    in   1   it is ERET
//  flush_ack      in   1   pipeline reports flush complete
//  commit_stall   out  1   commit must hold (state != IDLE)
//  flush_req      out  1   flush all stages younger than and incl. commit
//  hw_ip          out  N_HWINT  synchronised ext_int, to Cause.IP[7:2]
//  exc_valid      out  1   1-cycle record to CP0
//  exc_code/exc_pc/exc_ds/exc_badva out 5/32/1/32  record fields
//  eret_valid     out  1   1-cycle ERET notice to CP0
//  redirect_valid out  1   1-cycle fetch redirect
//  redirect_pc    out  32  redirect target
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; sync flops, flush counter, ack latch cleared. Async reset
//   mid-FLUSH/REDIRECT aborts the event with no record, redirect or ERET emitted.
//  hw_ip: 2-flop synchroniser per line; 2-cycle latency.
//  pend[7:0] = {timer_int | hw_ip[5], hw_ip[4:0], cause_ip_sw} & status_im (N_HWINT=6).
//  int_take = commit_valid & status_ie & ~status_exl & ~status_erl & |pend.
//  IDLE: commit inputs are sampled only here. Priority int_take > commit_exc > commit_eret.
//   Winner captured: code=0 (Int), else commit_code; pc, ds, badva from commit_*; type.
//   -> FLUSH next cycle; flush_req=1, commit_stall=1 from that cycle on. No event: stay IDLE.
//  FLUSH: counter counts up from 1 and saturates at FLUSH_CYCLES. flush_ack is latched, so an ack
//   arriving before the minimum still counts. Exit when count>=FLUSH_CYCLES and ack seen (latched
//   or current) -> REDIRECT. flush_req drops on that exit.
//  REDIRECT (exactly 1 cycle, then IDLE; counter and latch cleared):
//   exception/interrupt: exc_valid=1 with captured fields; redirect_pc=EXC_VECTOR.
//   ERET: eret_valid=1; redirect_pc=cp0_epc sampled this cycle.
//   redirect_valid=1 in both cases. EPC/BD selection from exc_pc/exc_ds is CP0's job.
//  commit_stall=1 in FLUSH and REDIRECT. Commit inputs are ignored outside IDLE.
//  exc_badva is passed through for every code; CP0 latches it only for AdEL/AdES.
//  Event rate: at most 1 per 3 cycles (IDLE->FLUSH->REDIRECT). A new event in the IDLE cycle right
//   after REDIRECT is accepted.
// TESTING
//  1 Reset: resetn=0 mid-FLUSH -> outputs 0 at once; after release no exc_valid/redirect.
//  2 Sync exc: commit_exc, code=4, pc=0x80001000, badva=0x3 (IDLE), ack 1 cycle later ->
//    flush_req 2 cycles; then exc_valid with code 4, badva 0x3; redirect_pc=0xBFC00380.
//  3 Priority: timer_int=1, IM[7]=1, IE=1, EXL=0, with commit_exc code 8 -> exc_code=0,
//    exc_pc=commit_pc.
//  4 Masking: same as 3 but EXL=1 -> code 8 taken. IM=0 with ext_int[0]=1 -> no interrupt.
//    hw_ip[0] rises 2 cycles after ext_int[0].
//  5 ERET: commit_eret, cp0_epc=0x80002004, ack delayed 5 cycles -> flush_req 5 cycles,
//    eret_valid + redirect_pc=0x80002004, exc_valid=0.
//  6 Early ack: flush_ack in first FLUSH cycle, FLUSH_CYCLES=2 -> REDIRECT still 2 cycles after
//    entry. Back-to-back events -> second accepted the cycle after REDIRECT.

Source files
------------

// File: rtl/cp0_exc_sequencer.sv
// rtl/cp0_exc_sequencer.sv - CP0 exception/interrupt entry and ERET sequencer with HW interrupt sync
module cp0_exc_sequencer #(
   parameter int          N_HWINT      = 6,
   parameter int          FLUSH_CYCLES = 2,
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [N_HWINT-1:0] ext_int,
   input  logic               timer_int,
   input  logic               status_ie,
   input  logic               status_exl,
   input  logic               status_erl,
   input  logic [7:0]         status_im,
   input  logic [1:0]         cause_ip_sw,
   input  logic [31:0]        cp0_epc,
   input  logic               commit_valid,
   input  logic [31:0]        commit_pc,
   input  logic               commit_ds,
   input  logic               commit_exc,
   input  logic [4:0]         commit_code,
   input  logic [31:0]        commit_badva,
   input  logic               commit_eret,
   input  logic               flush_ack,
   output logic               commit_stall,
   output logic               flush_req,
   output logic [N_HWINT-1:0] hw_ip,
   output logic               exc_valid,
   output logic [4:0]         exc_code,
   output logic [31:0]        exc_pc,
   output logic               exc_ds,
   output logic [31:0]        exc_badva,
   output logic               eret_valid,
   output logic               redirect_valid,
   output logic [31:0]        redirect_pc
);

   // Counter only needs to reach FLUSH_CYCLES, where it saturates.
   localparam int            CW        = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
   localparam logic [CW-1:0] FLUSH_MAX = CW'(FLUSH_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FLUSH,
      S_REDIRECT
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [N_HWINT-1:0] sync1;
   logic [N_HWINT-1:0] sync2;
   logic [5:0]         hw_pad;
   logic [7:0]         pend;
   logic               int_take;
   logic               evt_take;
   logic               flush_done;
   logic [CW-1:0]      cnt;
   logic               ack_seen;
   logic               cap_eret;
   logic [4:0]         cap_code;
   logic [31:0]        cap_pc;
   logic               cap_ds;
   logic [31:0]        cap_badva;

   assign hw_ip  = sync2;
   // Timer shares IP7 with the top HW line, as on the R4K-style Cause layout.
   assign hw_pad = 6'(sync2);
   assign pend   = {timer_int | hw_pad[5], hw_pad[4:0], cause_ip_sw} & status_im;

   assign int_take   = commit_valid & status_ie & ~status_exl & ~status_erl & (|pend);
   assign evt_take   = int_take | (commit_valid & (commit_exc | commit_eret));
   assign flush_done = (cnt >= FLUSH_MAX) && (ack_seen || flush_ack);

   // Two-flop synchroniser for the asynchronous interrupt lines.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= ext_int;
         sync2 <= sync1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Event capture, flush-length counter and sticky flush_ack.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt       <= '0;
         ack_seen  <= 1'b0;
         cap_eret  <= 1'b0;
         cap_code  <= '0;
         cap_pc    <= '0;
         cap_ds    <= 1'b0;
         cap_badva <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (evt_take) begin
                  cnt       <= CW'(1);
                  ack_seen  <= 1'b0;
                  cap_eret  <= ~int_take & ~commit_exc;
                  cap_code  <= int_take ? 5'd0 : commit_code;
                  cap_pc    <= commit_pc;
                  cap_ds    <= commit_ds;
                  cap_badva <= commit_badva;
               end
            end
            S_FLUSH: begin
               if (cnt < FLUSH_MAX) begin
                  cnt <= cnt + CW'(1);
               end
               ack_seen <= ack_seen | flush_ack;
            end
            default: begin
               cnt      <= '0;
               ack_seen <= 1'b0;
            end
         endcase
      end
   end

   // Next-state and output decode; record fields are only driven in REDIRECT.
   always_comb begin
      state_nxt      = state;
      commit_stall   = 1'b0;
      flush_req      = 1'b0;
      exc_valid      = 1'b0;
      exc_code       = '0;
      exc_pc         = '0;
      exc_ds         = 1'b0;
      exc_badva      = '0;
      eret_valid     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      case (state)
         S_IDLE: begin
            if (evt_take) begin
               state_nxt = S_FLUSH;
            end
         end
         S_FLUSH: begin
            commit_stall = 1'b1;
            flush_req    = 1'b1;
            if (flush_done) begin
               state_nxt = S_REDIRECT;
            end
         end
         S_REDIRECT: begin
            commit_stall   = 1'b1;
            redirect_valid = 1'b1;
            state_nxt      = S_IDLE;
            if (cap_eret) begin
               eret_valid  = 1'b1;
               redirect_pc = cp0_epc;
            end else begin
               exc_valid   = 1'b1;
               exc_code    = cap_code;
               exc_pc      = cap_pc;
               exc_ds      = cap_ds;
               exc_badva   = cap_badva;
               redirect_pc = EXC_VECTOR;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_cp0_exc_sequencer.sv
// tb/tb_cp0_exc_sequencer.sv - directed table-driven bench for cp0_exc_sequencer
module tb_cp0_exc_sequencer;

   localparam int          K_NONE = 0;
   localparam int          K_EXC  = 1;
   localparam int          K_ERET = 2;
   localparam logic [31:0] VEC    = 32'hBFC00380;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [5:0]  ext_int = '0;
   logic        timer_int = 1'b0;
   logic        status_ie = 1'b0;
   logic        status_exl = 1'b0;
   logic        status_erl = 1'b0;
   logic [7:0]  status_im = '0;
   logic [1:0]  cause_ip_sw = '0;
   logic [31:0] cp0_epc = '0;
   logic        commit_valid = 1'b0;
   logic [31:0] commit_pc = '0;
   logic        commit_ds = 1'b0;
   logic        commit_exc = 1'b0;
   logic [4:0]  commit_code = '0;
   logic [31:0] commit_badva = '0;
   logic        commit_eret = 1'b0;
   logic        flush_ack = 1'b0;
   logic        commit_stall;
   logic        flush_req;
   logic [5:0]  hw_ip;
   logic        exc_valid;
   logic [4:0]  exc_code;
   logic [31:0] exc_pc;
   logic        exc_ds;
   logic [31:0] exc_badva;
   logic        eret_valid;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int checks = 0;
   int errors = 0;

   cp0_exc_sequencer #(
      .N_HWINT     (6),
      .FLUSH_CYCLES(2),
      .EXC_VECTOR  (VEC)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .ext_int       (ext_int),
      .timer_int     (timer_int),
      .status_ie     (status_ie),
      .status_exl    (status_exl),
      .status_erl    (status_erl),
      .status_im     (status_im),
      .cause_ip_sw   (cause_ip_sw),
      .cp0_epc       (cp0_epc),
      .commit_valid  (commit_valid),
      .commit_pc     (commit_pc),
      .commit_ds     (commit_ds),
      .commit_exc    (commit_exc),
      .commit_code   (commit_code),
      .commit_badva  (commit_badva),
      .commit_eret   (commit_eret),
      .flush_ack     (flush_ack),
      .commit_stall  (commit_stall),
      .flush_req     (flush_req),
      .hw_ip         (hw_ip),
      .exc_valid     (exc_valid),
      .exc_code      (exc_code),
      .exc_pc        (exc_pc),
      .exc_ds        (exc_ds),
      .exc_badva     (exc_badva),
      .eret_valid    (eret_valid),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        cv;
      logic        exc;
      logic        eret;
      logic        ds;
      logic        timer;
      logic        ie;
      logic        exl;
      logic        erl;
      logic [1:0]  sw;
      logic [7:0]  im;
      logic [4:0]  code;
      logic [31:0] pc;
      logic [31:0] badva;
      logic [31:0] epc;
      int          ack_at;
      int          kind;
      logic [4:0]  x_code;
      int          x_flush;
      logic [31:0] x_rpc;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Issue one commit in IDLE, ack the flush in FLUSH cycle ack_at, check the REDIRECT record.
   task automatic run_vec(input vec_t v, input int idx);
      int n;
      @(negedge clk);
      commit_valid = v.cv;
      commit_exc   = v.exc;
      commit_eret  = v.eret;
      commit_ds    = v.ds;
      commit_code  = v.code;
      commit_pc    = v.pc;
      commit_badva = v.badva;
      timer_int    = v.timer;
      status_ie    = v.ie;
      status_exl   = v.exl;
      status_erl   = v.erl;
      cause_ip_sw  = v.sw;
      status_im    = v.im;
      cp0_epc      = v.epc;
      flush_ack    = 1'b0;
      @(negedge clk);
      commit_valid = 1'b0;
      commit_exc   = 1'b0;
      commit_eret  = 1'b0;
      if (v.kind == K_NONE) begin
         chk($sformatf("v%0d no_event flush_req", idx), 32'(flush_req), 32'd0);
         chk($sformatf("v%0d no_event stall", idx), 32'(commit_stall), 32'd0);
      end else begin
         n = 0;
         while (flush_req && n < 40) begin
            n++;
            flush_ack = (n == v.ack_at);
            @(negedge clk);
         end
         flush_ack = 1'b0;
         chk($sformatf("v%0d flush_cycles", idx), 32'(n), 32'(v.x_flush));
         chk($sformatf("v%0d redirect_valid", idx), 32'(redirect_valid), 32'd1);
         chk($sformatf("v%0d redirect_pc", idx), redirect_pc, v.x_rpc);
         chk($sformatf("v%0d stall_in_redirect", idx), 32'(commit_stall), 32'd1);
         chk($sformatf("v%0d exc_valid", idx), 32'(exc_valid), 32'(v.kind == K_EXC));
         chk($sformatf("v%0d eret_valid", idx), 32'(eret_valid), 32'(v.kind == K_ERET));
         if (v.kind == K_EXC) begin
            chk($sformatf("v%0d exc_code", idx), 32'(exc_code), 32'(v.x_code));
            chk($sformatf("v%0d exc_pc", idx), exc_pc, v.pc);
            chk($sformatf("v%0d exc_ds", idx), 32'(exc_ds), 32'(v.ds));
            chk($sformatf("v%0d exc_badva", idx), exc_badva, v.badva);
         end
         @(negedge clk);
         chk($sformatf("v%0d redirect_one_cycle", idx), 32'(redirect_valid), 32'd0);
         chk($sformatf("v%0d stall_released", idx), 32'(commit_stall), 32'd0);
      end
      timer_int   = 1'b0;
      cause_ip_sw = 2'b00;
   endtask

   initial begin
      int   bad;
      vec_t hv;

      //           cv exc eret ds tmr ie exl erl sw     im     code  pc            badva         epc           ack kind    xcode xfl rpc
      vecs[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 8'h00, 5'd4,  32'h80001000, 32'h00000003, 32'h0,        1, K_EXC,  5'd4,  2, VEC};
      vecs[1]  = '{1, 1, 0, 1, 1, 1, 0, 0, 2'b00, 8'h80, 5'd8,  32'h80000200, 32'h00001234, 32'h0,        2, K_EXC,  5'd0,  2, VEC};
      vecs[2]  = '{1, 1, 0, 0, 1, 1, 1, 0, 2'b00, 8'h80, 5'd8,  32'h80000300, 32'h00000000, 32'h0,        3, K_EXC,  5'd8,  3, VEC};
      vecs[3]  = '{1, 1, 0, 0, 1, 1, 0, 1, 2'b00, 8'h80, 5'd8,  32'h80000400, 32'h00000000, 32'h0,        1, K_EXC,  5'd8,  2, VEC};
      vecs[4]  = '{1, 0, 0, 0, 1, 1, 0, 0, 2'b00, 8'h00, 5'd0,  32'h80000500, 32'h00000000, 32'h0,        1, K_NONE, 5'd0,  0, 32'h0};
      vecs[5]  = '{1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 8'h00, 5'd0,  32'h80000600, 32'h00000000, 32'h80002004, 5, K_ERET, 5'd0,  5, 32'h80002004};
      vecs[6]  = '{1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 8'h00, 5'd10, 32'h80000700, 32'h0000DEAD, 32'h80003000, 2, K_EXC,  5'd10, 2, VEC};
      vecs[7]  = '{1, 0, 0, 1, 0, 1, 0, 0, 2'b01, 8'h01, 5'd0,  32'h80000800, 32'h00000000, 32'h0,        1, K_EXC,  5'd0,  2, VEC};
      vecs[8]  = '{0, 1, 0, 0, 1, 1, 0, 0, 2'b00, 8'h80, 5'd4,  32'h80000900, 32'h00000000, 32'h0,        1, K_NONE, 5'd0,  0, 32'h0};
      vecs[9]  = '{1, 0, 1, 0, 0, 1, 0, 0, 2'b10, 8'h01, 5'd0,  32'h80000A00, 32'h00000000, 32'h8000100C, 3, K_ERET, 5'd0,  3, 32'h8000100C};
      vecs[10] = '{1, 0, 1, 0, 0, 1, 0, 0, 2'b10, 8'h02, 5'd0,  32'h80000B00, 32'h00000000, 32'h80004000, 2, K_EXC,  5'd0,  2, VEC};

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset flush_req", 32'(flush_req), 32'd0);
      chk("reset commit_stall", 32'(commit_stall), 32'd0);
      chk("reset hw_ip", 32'(hw_ip), 32'd0);
      chk("reset exc_valid", 32'(exc_valid), 32'd0);
      chk("reset redirect_valid", 32'(redirect_valid), 32'd0);
      resetn = 1'b1;

      // Table of single events
      for (int i = 0; i < 11; i++) begin
         run_vec(vecs[i], i);
      end

      // Asynchronous reset in the middle of FLUSH aborts the event
      @(negedge clk);
      commit_valid = 1'b1;
      commit_exc   = 1'b1;
      commit_code  = 5'd5;
      commit_pc    = 32'h80005000;
      status_ie    = 1'b0;
      @(negedge clk);
      commit_valid = 1'b0;
      commit_exc   = 1'b0;
      chk("abort in_flush", 32'(flush_req), 32'd1);
      #2 resetn = 1'b0;
      #1;
      chk("abort flush_req_now", 32'(flush_req), 32'd0);
      chk("abort stall_now", 32'(commit_stall), 32'd0);
      chk("abort redirect_now", 32'(redirect_valid), 32'd0);
      flush_ack = 1'b1;
      @(negedge clk);
      resetn = 1'b1;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (exc_valid || redirect_valid || eret_valid || flush_req) bad = 1;
      end
      flush_ack = 1'b0;
      chk("abort no_record_after_release", 32'(bad), 32'd0);

      // hw_ip latency and IM masking of a HW line
      @(negedge clk);
      status_ie    = 1'b1;
      status_im    = 8'h00;
      commit_valid = 1'b1;
      commit_pc    = 32'h80006000;
      ext_int      = 6'b000001;
      @(negedge clk);
      chk("hw_ip after_1", 32'(hw_ip), 32'd0);
      @(negedge clk);
      chk("hw_ip after_2", 32'(hw_ip), 32'd1);
      @(negedge clk);
      chk("hw_ip masked no_flush", 32'(flush_req), 32'd0);
      commit_valid = 1'b0;
      hv = '{1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 8'h04, 5'd0, 32'h80006100, 32'h0, 32'h0, 1, K_EXC, 5'd0, 2, VEC};
      run_vec(hv, 100);
      ext_int   = '0;
      status_ie = 1'b0;

      // Early ack held high, commit inputs changed during FLUSH, back-to-back events
      @(negedge clk);
      commit_valid = 1'b1;
      commit_exc   = 1'b1;
      commit_code  = 5'd4;
      commit_pc    = 32'h80007000;
      commit_badva = 32'h11;
      flush_ack    = 1'b1;
      @(negedge clk);
      chk("b2b first flush", 32'(flush_req), 32'd1);
      commit_code  = 5'd5;
      commit_pc    = 32'h80007100;
      commit_badva = 32'h22;
      @(negedge clk);
      chk("b2b flush_min_len", 32'(flush_req), 32'd1);
      @(negedge clk);
      chk("b2b first redirect", 32'(redirect_valid), 32'd1);
      chk("b2b first exc_pc", exc_pc, 32'h80007000);
      chk("b2b first exc_code", 32'(exc_code), 32'd4);
      @(negedge clk);
      chk("b2b idle gap stall", 32'(commit_stall), 32'd0);
      @(negedge clk);
      commit_valid = 1'b0;
      commit_exc   = 1'b0;
      chk("b2b second flush", 32'(flush_req), 32'd1);
      @(negedge clk);
      @(negedge clk);
      flush_ack = 1'b0;
      chk("b2b second redirect", 32'(redirect_valid), 32'd1);
      chk("b2b second exc_pc", exc_pc, 32'h80007100);
      chk("b2b second exc_code", 32'(exc_code), 32'd5);
      chk("b2b second badva", exc_badva, 32'h22);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
